ram_burst_ctrl: RTL and testbench
=================================

// Module: ram_burst_ctrl
// PURPOSE
//  Command-driven burst master in front of the 1Kx8 single-port RAM (cs/wr/rd, 10b addr, 8b data).
//  Takes write/read burst commands plus valid/ready byte streams; sequences RAM strobes and addresses.
//  Read data returns through a small FIFO. Upstream: loader/UART logic. Downstream: the RAM.
// PARAMETERS
//  AW      10  RAM address width (1024 bytes)
//  DW      8   data width
//  RDEPTH  4   read-return FIFO depth (power of 2, >=2)
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  cmd_valid  in   1   command offered
//  cmd_ready  out  1   command accepted when valid&ready
//  cmd_write  in   1   1=write burst, 0=read burst
//  cmd_addr   in   AW  start address
//  cmd_len    in   AW  beats minus one (0 -> 1 byte, 1023 -> 1024 bytes)
//  wdata      in   DW  write byte
//  wvalid     in   1   write byte offered
//  wready     out  1   write byte accepted when wvalid&wready
//  rdata      out  DW  read byte (FIFO head)
//  rvalid     out  1   rdata valid
//  rready     in   1   consumer takes rdata when rvalid&rready
//  busy       out  1   burst in progress (state != IDLE or FIFO not empty)
//  done       out  1   one-cycle pulse at burst completion
//  mem_cs     out  1   RAM chip select
//  mem_wr     out  1   RAM write strobe
//  mem_rd     out  1   RAM read strobe
//  mem_addr   out  AW  RAM address
//  mem_wdata  out  DW  data to RAM (top level drives the RAM data pin with it while mem_wr=1)
//  mem_rdata  in   DW  data from RAM (registered RAM output)
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=0 during rst, 1 the cycle after; wready/rvalid/busy/done/mem_* = 0; FIFO flushed.
//  FSM: IDLE -> WRITE (cmd_write=1) or READ (cmd_write=0) on cmd handshake; latch addr, beat counter=cmd_len.
//  IDLE: cmd_ready=1 only in IDLE with empty FIFO; no other state accepts commands.
//  WRITE: wready=1. Each handshake at edge k registers mem_cs=mem_wr=1, mem_addr=cur, mem_wdata=wdata for cycle k+1.
//    RAM writes at edge ending k+1. addr increments; counter decrements. wvalid gaps -> strobes low that cycle.
//    Last beat (counter==0): -> IDLE, done=1 in the cycle mem_wr strobes the last byte.
//  READ: issue when (fifo_count + inflight) < RDEPTH: registered mem_cs=mem_rd=1, mem_addr=cur in cycle n.
//    mem_rdata valid in cycle n+1, pushed into FIFO at that edge; rvalid from cycle n+2. Peak 1 byte/cycle.
//    After last issue -> DRAIN; DRAIN -> IDLE when inflight=0 and FIFO empty; done=1 on final rvalid&rready cycle.
//  Address arithmetic modulo 2^AW: 0x3FF + 1 -> 0x000; no error, no stall at wrap.
//  mem_wr and mem_rd never both 1; mem_cs=0 whenever neither strobe is 1.
//  rready low: FIFO fills, issue stalls at credit limit; no byte lost or duplicated; rdata stable while rvalid&!rready.
//  wvalid/rready ignored in IDLE; wdata beats beyond cmd_len+1 are not accepted (wready=0).
//  rst mid-burst: takes effect at that edge; pending registered strobe dropped (no RAM access next cycle),
//    FIFO and inflight cleared, no done pulse; partially written bytes remain in RAM.
// STRUCTURE
//  Shared package: state encoding (IDLE, WRITE, READ, DRAIN), AW/DW defaults.
//  Sub-module ram_rd_fifo: sync FIFO, DW x RDEPTH, push/pop/count/empty/full, sync reset flush.
//  Top: FSM, addr/beat counters, inflight flag, registered RAM strobes, done generation.
// TESTING (bench uses behavioural model of the RAM: registered read, write on posedge)
//  1. Write len=3 at 0x3FE, bytes A1 B2 C3 D4 -> mem_wr at 0x3FE,0x3FF,0x000,0x001; done once; cmd_ready back next cycle.
//  2. Read same burst, rready=1 -> rdata A1 B2 C3 D4, first rvalid 2 cycles after first mem_rd; then 1/cycle.
//  3. Read len=15, rready toggles 1/0 random -> 16 bytes in order, never >RDEPTH outstanding, no mem_wr seen.
//  4. len=0 write then read of 0x155 with 5A -> exactly one strobe each; read returns 5A; two done pulses.
//  5. Write with wvalid gaps (1 beat every 3 cycles) -> strobes only on handshake cycles; data correct.
//  6. rst during read after 2 of 8 beats -> next cycle all outputs 0, rvalid 0; new command accepted.

Source files
------------

// File: rtl/ram_burst_ctrl_pkg.sv
// Shared definitions for the RAM burst controller slice.
//   AW_DEF / DW_DEF / RDEPTH_DEF : default address width, data width, read FIFO depth
//   state_t                      : controller state encoding
package ram_burst_ctrl_pkg;

  localparam int AW_DEF     = 10;
  localparam int DW_DEF     = 8;
  localparam int RDEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/ram_rd_fifo.sv
// Synchronous read-return FIFO, DW x DEPTH (DEPTH power of two, >= 2).
//   clk, rst    : clock, synchronous active-high flush
//   push, din   : write side (ignored when full)
//   pop, dout   : read side, dout is the head entry (ignored when empty)
//   count       : current occupancy
//   empty, full : status flags
module ram_rd_fifo
  import ram_burst_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = RDEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          din,
  input  logic                   pop,
  output logic [DW-1:0]          dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == (PW+1)'(DEPTH));

endmodule

// File: rtl/ram_burst_ctrl.sv
// Command-driven burst master for a single-port RAM with registered read data.
//   clk, rst                       : clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/len : burst command (len = beats - 1)
//   wdata/wvalid/wready            : write byte stream
//   rdata/rvalid/rready            : read byte stream (FIFO head)
//   busy, done                     : burst in progress, one-cycle completion pulse
//   mem_cs/wr/rd/addr/wdata/rdata  : registered RAM strobes and data
module ram_burst_ctrl
  import ram_burst_ctrl_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RDEPTH = RDEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] wdata,
  input  logic          wvalid,
  output logic          wready,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  input  logic          rready,
  output logic          busy,
  output logic          done,
  output logic          mem_cs,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(RDEPTH) + 1;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_cnt;
  logic          r_mem_cs;
  logic          r_mem_wr;
  logic          r_mem_rd;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_rd_d1;
  logic          r_wr_done;

  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic          w_fifo_pop;
  logic [CW:0]   w_occ;
  logic          w_can_issue;
  logic          w_inflight;
  logic          w_rd_done;
  logic          w_drain_done;

  // Credit covers FIFO contents plus the strobe cycle and the data-return cycle.
  assign w_inflight  = r_mem_rd || r_rd_d1;
  assign w_occ       = (CW+1)'(w_fifo_count) + (CW+1)'(r_mem_rd) + (CW+1)'(r_rd_d1);
  assign w_can_issue = !w_fifo_full && (w_occ < (CW+1)'(RDEPTH));

  assign cmd_ready  = !rst && (r_state == ST_IDLE) && w_fifo_empty;
  assign wready     = !rst && (r_state == ST_WRITE);
  assign rvalid     = !rst && !w_fifo_empty;
  assign w_fifo_pop = rvalid && rready;
  assign busy       = !rst && ((r_state != ST_IDLE) || !w_fifo_empty);

  // Final read byte leaves the FIFO with nothing left in flight.
  assign w_rd_done    = !rst && (r_state == ST_DRAIN) && !w_inflight &&
                        (w_fifo_count == CW'(1)) && rready;
  assign w_drain_done = !w_inflight && (w_fifo_empty || w_rd_done);
  assign done         = r_wr_done || w_rd_done;

  assign mem_cs    = r_mem_cs;
  assign mem_wr    = r_mem_wr;
  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_mem_cs    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_d1     <= 1'b0;
      r_wr_done   <= 1'b0;
    end else begin
      r_mem_cs  <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_mem_rd  <= 1'b0;
      r_wr_done <= 1'b0;
      r_rd_d1   <= r_mem_rd;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_addr  <= cmd_addr;
            r_cnt   <= cmd_len;
            r_state <= cmd_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (wvalid) begin
            r_mem_cs    <= 1'b1;
            r_mem_wr    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= wdata;
            r_addr      <= r_addr + AW'(1);
            if (r_cnt == '0) begin
              r_state   <= ST_IDLE;
              r_wr_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt - AW'(1);
            end
          end
        end
        ST_READ: begin
          if (w_can_issue) begin
            r_mem_cs   <= 1'b1;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= r_addr;
            r_addr     <= r_addr + AW'(1);
            if (r_cnt == '0) begin
              r_state <= ST_DRAIN;
            end else begin
              r_cnt <= r_cnt - AW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_drain_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // r_rd_d1 marks the cycle the registered RAM output holds the requested byte.
  ram_rd_fifo #(
    .DW    (DW),
    .DEPTH (RDEPTH)
  ) u_rd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_rd_d1),
    .din   (mem_rdata),
    .pop   (w_fifo_pop),
    .dout  (rdata),
    .count (w_fifo_count),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl with a behavioural RAM and a byte-array reference memory.
module tb_ram_burst_ctrl;

  localparam int AW     = 10;
  localparam int DW     = 8;
  localparam int RDEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic [DW-1:0] wdata = '0;
  logic          wvalid = 1'b0;
  logic          rready = 1'b0;
  logic          cmd_ready, wready, rvalid, busy, done;
  logic          mem_cs, mem_wr, mem_rd;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  ram_burst_ctrl #(
    .AW     (AW),
    .DW     (DW),
    .RDEPTH (RDEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wdata     (wdata),
    .wvalid    (wvalid),
    .wready    (wready),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rready    (rready),
    .busy      (busy),
    .done      (done),
    .mem_cs    (mem_cs),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Behavioural RAM: write on posedge, registered read.
  logic [DW-1:0] ram [1024];
  always @(posedge clk) begin
    if (mem_cs && mem_wr) ram[mem_addr] <= mem_wdata;
    if (mem_cs && mem_rd) mem_rdata <= ram[mem_addr];
  end

  // Reference contents: what RAM must hold after every completed write burst.
  logic [DW-1:0] model_mem [1024];
  logic [DW-1:0] wbytes [1024];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_ev_t;

  wr_ev_t        wr_log[$];
  int            wr_cycle[$];
  int            hs_cycle[$];
  logic [AW-1:0] rd_log[$];
  int            rd_cycle[$];
  logic [DW-1:0] rx_log[$];
  int            rx_cycle[$];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc = 0;
  int done_cnt, outstanding, max_out, inv_bad, stab_bad;
  bit prev_stall;
  logic [DW-1:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete(); wr_cycle.delete(); hs_cycle.delete();
    rd_log.delete(); rd_cycle.delete(); rx_log.delete(); rx_cycle.delete();
    done_cnt = 0; outstanding = 0; max_out = 0; inv_bad = 0; stab_bad = 0;
    prev_stall = 1'b0; prev_data = '0;
  endtask

  // Called once per cycle, mid-cycle, after inputs for that cycle are applied.
  task automatic sample_cycle();
    cyc++;
    if (mem_wr && mem_rd) inv_bad++;
    if (mem_cs !== (mem_wr | mem_rd)) inv_bad++;
    if (prev_stall && !(rvalid && rdata === prev_data)) stab_bad++;
    prev_stall = rvalid && !rready;
    prev_data  = rdata;
    if (mem_cs && mem_wr) begin
      wr_log.push_back('{mem_addr, mem_wdata});
      wr_cycle.push_back(cyc);
    end
    if (mem_cs && mem_rd) begin
      rd_log.push_back(mem_addr);
      rd_cycle.push_back(cyc);
      outstanding++;
      if (outstanding > max_out) max_out = outstanding;
    end
    if (rvalid && rready) begin
      rx_log.push_back(rdata);
      rx_cycle.push_back(cyc);
      outstanding--;
    end
    if (done) done_cnt++;
  endtask

  task automatic issue_cmd(input bit wr, input logic [AW-1:0] addr, input logic [AW-1:0] len);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
      wvalid = 1'b0; rready = 1'b0;
      #1;
      acc = cmd_ready;
      sample_cycle();
      t++;
    end
    check("cmd_accept", 32'(acc), 32'd1);
  endtask

  task automatic run_burst(input bit wr, input logic [AW-1:0] addr, input logic [AW-1:0] len,
                           input int gap, input int rmode, input int exp_lat, input int exp_strobes);
    int beats, idx, t, limit, bad;
    logic [AW-1:0] a;
    beats = int'(len) + 1;
    clear_logs();
    issue_cmd(wr, addr, len);
    idx = 0; t = 0; limit = 20 * beats + 100;
    while (done_cnt == 0 && t < limit) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (wr) begin
        wvalid = (idx < beats) && ((t % gap) == 0);
        wdata  = wbytes[idx % 1024];
      end else begin
        case (rmode)
          0:       rready = 1'b1;
          1:       rready = 1'($urandom_range(0, 1));
          default: rready = (t >= 12);
        endcase
      end
      #1;
      sample_cycle();
      if (wr && wvalid && wready) begin
        hs_cycle.push_back(cyc);
        idx++;
      end
      t++;
    end
    check("burst_finished", 32'(done_cnt != 0), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; wvalid = 1'b1; rready = 1'b1;
    #1;
    check("wready_idle", 32'(wready), 32'd0);
    check("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
    sample_cycle();
    @(negedge clk); wvalid = 1'b0; rready = 1'b0; #1; sample_cycle();
    @(negedge clk); #1; sample_cycle();
    check("busy_idle", 32'(busy), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("strobe_invariant", 32'(inv_bad), 32'd0);
    check("rdata_stable", 32'(stab_bad), 32'd0);
    bad = 0;
    if (wr) begin
      check("wr_strobes", 32'(wr_log.size()), 32'(exp_strobes));
      check("rd_strobes_in_write", 32'(rd_log.size()), 32'd0);
      for (int i = 0; i < wr_log.size(); i++) begin
        a = addr + AW'(i);
        if (i >= beats || i >= hs_cycle.size()) bad++;
        else if (wr_log[i].addr !== a || wr_log[i].data !== wbytes[i] ||
                 wr_cycle[i] != hs_cycle[i] + 1) bad++;
      end
      check("wr_addr_data_timing", 32'(bad), 32'd0);
      for (int i = 0; i < beats; i++) begin
        a = addr + AW'(i);
        model_mem[a] = wbytes[i];
      end
    end else begin
      check("rd_strobes", 32'(rd_log.size()), 32'(exp_strobes));
      check("wr_strobes_in_read", 32'(wr_log.size()), 32'd0);
      check("rd_bytes", 32'(rx_log.size()), 32'(beats));
      for (int i = 0; i < rx_log.size(); i++) begin
        a = addr + AW'(i);
        if (rx_log[i] !== model_mem[a]) bad++;
        if (i < rd_log.size() && rd_log[i] !== a) bad++;
      end
      check("rd_addr_data", 32'(bad), 32'd0);
      check("outstanding_le_depth", 32'(max_out <= RDEPTH), 32'd1);
      if (exp_lat >= 0 && rx_cycle.size() > 0 && rd_cycle.size() > 0)
        check("first_rvalid_latency", 32'(rx_cycle[0] - rd_cycle[0]), 32'(exp_lat));
    end
  endtask

  task automatic fill_bytes(input int dsel, input int beats);
    logic [DW-1:0] fixed4 [4];
    fixed4[0] = 8'hA1; fixed4[1] = 8'hB2; fixed4[2] = 8'hC3; fixed4[3] = 8'hD4;
    for (int i = 0; i < beats; i++) begin
      case (dsel)
        1:       wbytes[i] = (i < 4) ? fixed4[i] : 8'h00;
        2:       wbytes[i] = 8'h5A;
        default: wbytes[i] = 8'($urandom);
      endcase
    end
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
    int            gap;
    int            rmode;
    int            dsel;
    int            exp_lat;
    int            exp_strobes;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 10'h000, 10'h3FF, 1, 0, 0, -1, 1024}; // fill whole RAM
    vecs[1] = '{1'b1, 10'h3FE, 10'd3,   1, 0, 1, -1, 4};    // wrap write A1..D4
    vecs[2] = '{1'b0, 10'h3FE, 10'd3,   1, 0, 0,  2, 4};    // read back, latency 2
    vecs[3] = '{1'b0, 10'h3F8, 10'd15,  1, 1, 0, -1, 16};   // random rready
    vecs[4] = '{1'b1, 10'h155, 10'd0,   1, 0, 2, -1, 1};    // single byte 5A
    vecs[5] = '{1'b0, 10'h155, 10'd0,   1, 0, 0,  2, 1};
    vecs[6] = '{1'b1, 10'h200, 10'd5,   3, 0, 0, -1, 6};    // wvalid every 3rd cycle
    vecs[7] = '{1'b0, 10'h200, 10'd5,   1, 0, 0,  2, 6};
    vecs[8] = '{1'b0, 10'h3F8, 10'd15,  1, 2, 0, -1, 16};   // rready low 12 cycles
    vecs[9] = '{1'b0, 10'h000, 10'd1,   1, 0, 0,  2, 2};

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_mem_cs", 32'(mem_cs), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int v = 0; v < 10; v++) begin
      fill_bytes(vecs[v].dsel, int'(vecs[v].len) + 1);
      run_burst(vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].gap,
                vecs[v].rmode, vecs[v].exp_lat, vecs[v].exp_strobes);
    end

    // Randomized bursts against the reference memory.
    for (int k = 0; k < 12; k++) begin
      bit            rwr;
      logic [AW-1:0] raddr, rlen;
      rwr   = 1'($urandom_range(0, 1));
      raddr = AW'($urandom);
      rlen  = AW'($urandom_range(0, 40));
      fill_bytes(0, int'(rlen) + 1);
      run_burst(rwr, raddr, rlen, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                -1, int'(rlen) + 1);
    end

    // Reset in the middle of an 8-beat read, after two bytes consumed.
    begin
      int t;
      clear_logs();
      issue_cmd(1'b0, 10'h300, 10'd7);
      t = 0;
      while (rx_log.size() < 2 && t < 40) begin
        @(negedge clk);
        cmd_valid = 1'b0; rready = 1'b1;
        #1;
        sample_cycle();
        t++;
      end
      check("midrst_pops_before", 32'(rx_log.size()), 32'd2);
      @(negedge clk);
      rst = 1'b1; rready = 1'b1;
      #1;
      check("midrst_cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
      sample_cycle();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_mem_cs", 32'(mem_cs), 32'd0);
      check("midrst_mem_wr", 32'(mem_wr), 32'd0);
      check("midrst_mem_rd", 32'(mem_rd), 32'd0);
      check("midrst_rvalid", 32'(rvalid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_wready", 32'(wready), 32'd0);
      check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      sample_cycle();
      @(negedge clk); rready = 1'b0; #1;
      check("midrst_rvalid_next", 32'(rvalid), 32'd0);
      check("midrst_mem_cs_next", 32'(mem_cs), 32'd0);
      sample_cycle();
      check("midrst_no_done", 32'(done_cnt), 32'd0);
      fill_bytes(0, 3);
      run_burst(1'b1, 10'h301, 10'd2, 1, 0, -1, 3);
      run_burst(1'b0, 10'h2FF, 10'd4, 1, 0, 2, 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
